// File: rtl/dsp_mc_unit_if.sv
// dsp_mc_unit_if
//   Bundles the control pulses, sample/coefficient buses and processed
//   outputs of dsp_mc_unit.
//
//   Handshake semantics: there is no valid/ready back-pressure on this port.
//   Every control input (tick_in, cfg_in, level_in, clr_in) is a one-cycle
//   strobe that is sampled on the rising clock edge. The data buses that go
//   with a strobe (audio_in, cfg_reg_in/coef_in, level_reg_in) only need to
//   be stable in the cycle where the strobe is high. tick_out is a one-cycle
//   strobe that marks the cycle in which audio_out takes a new value.
//   busy_out tells the sender when a tick_in would be dropped.
//
//   Modports:
//     master : control front end (drives the inputs, observes the outputs)
//     slave  : dsp_mc_unit
//   state_dbg exposes the FSM state (IDLE=0, MAC=1, SCALE=2, OUT=3) for
//   observation only.
interface dsp_mc_unit_if #(
    parameter int CHANNELS = 2,
    parameter int TAPS     = 32,
    parameter int DATA_W   = 24,
    parameter int COEF_W   = 32
);
    logic                         tick_in;
    logic                         cfg_in;
    logic                         level_in;
    logic                         clr_in;
    logic [CHANNELS*DATA_W-1:0]   audio_in;
    logic [TAPS*COEF_W-1:0]       coef_in;
    logic [CHANNELS*16-1:0]       level_reg_in;
    logic [31:0]                  cfg_reg_in;
    logic [CHANNELS*DATA_W-1:0]   audio_out;
    logic                         tick_out;
    logic                         busy_out;
    logic [1:0]                   state_dbg;

    modport master (
        output tick_in, cfg_in, level_in, clr_in,
        output audio_in, coef_in, level_reg_in, cfg_reg_in,
        input  audio_out, tick_out, busy_out, state_dbg
    );

    modport slave (
        input  tick_in, cfg_in, level_in, clr_in,
        input  audio_in, coef_in, level_reg_in, cfg_reg_in,
        output audio_out, tick_out, busy_out, state_dbg
    );
endinterface

// File: rtl/dsp_mc_unit.sv
// dsp_mc_unit
//   Multi-channel audio datapath: per-channel circular delay lines feeding a
//   TAPS-tap FIR that is computed with one time-shared MAC, followed by a
//   per-channel Q1.15 level gain, optional mono down-mix and saturation to
//   DATA_W bits. All channel results are published together with tick_out.
//
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : dsp_mc_unit_if.slave (strobes, sample/coef/level/cfg inputs,
//             audio_out, tick_out, busy_out, state_dbg)
//
//   Latency from the edge that samples tick_in to the edge that updates
//   audio_out: CHANNELS*(TAPS+1)+1 with the filter on, CHANNELS+1 bypassed.
module dsp_mc_unit #(
    parameter int CHANNELS = 2,
    parameter int TAPS     = 32,
    parameter int DATA_W   = 24,
    parameter int COEF_W   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    dsp_mc_unit_if.slave  bus
);
    localparam int TW = $clog2(TAPS);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW = DATA_W + COEF_W;      // MAC product width
    localparam int AW = PW + TW;              // accumulator width (no overflow over TAPS terms)
    localparam int GW = DATA_W + 17;          // sample * unsigned 16-bit gain, signed

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_SCALE = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                      state;
    logic                        busy_r;
    logic                        tick_r;
    logic [CHANNELS*DATA_W-1:0]  audio_r;

    logic [DATA_W-1:0]           dly    [CHANNELS][TAPS];
    logic [DATA_W-1:0]           shadow [CHANNELS];
    logic [TW-1:0]               wptr;
    logic [TW-1:0]               k;
    logic [CW-1:0]               ch;
    logic signed [AW-1:0]        acc;

    logic                        filt_en;
    logic                        mono_en;
    logic [TAPS*COEF_W-1:0]      coef_r;
    logic [CHANNELS*16-1:0]      level_r;

    // Loads requested while a frame is in flight wait here until the frame ends.
    logic                        pend_cfg;
    logic                        pend_lvl;
    logic                        snap_filt;
    logic                        snap_mono;
    logic [TAPS*COEF_W-1:0]      snap_coef;
    logic [CHANNELS*16-1:0]      snap_lvl;

    // ------------------------------------------------------------------
    // Saturation helpers: clamp when the bits above the DATA_W sign bit are
    // not a pure sign extension.
    // ------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] sat_acc(input logic signed [AW-1:0] v);
        if (!v[AW-1] && (|v[AW-2:DATA_W-1]))
            return {1'b0, {(DATA_W-1){1'b1}}};
        else if (v[AW-1] && !(&v[AW-2:DATA_W-1]))
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return v[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] sat_gain(input logic signed [GW-1:0] v);
        if (!v[GW-1] && (|v[GW-2:DATA_W-1]))
            return {1'b0, {(DATA_W-1){1'b1}}};
        else if (v[GW-1] && !(&v[GW-2:DATA_W-1]))
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return v[DATA_W-1:0];
    endfunction

    // A cfg_in arriving together with tick_in in IDLE must already steer
    // this frame, so the routing decisions look through to the input.
    logic eff_filt;
    logic eff_mono;
    assign eff_filt = bus.cfg_in ? bus.cfg_reg_in[0] : filt_en;
    assign eff_mono = bus.cfg_in ? bus.cfg_reg_in[1] : mono_en;

    logic unused_cfg_bits;
    assign unused_cfg_bits = ^bus.cfg_reg_in[31:2];

    // Sample actually written into each delay line.
    logic [DATA_W-1:0] in_sample [CHANNELS];

    generate
        if (CHANNELS >= 2) begin : g_mono
            logic signed [DATA_W:0] mono_sum;
            always_comb begin
                mono_sum = $signed({bus.audio_in[DATA_W-1], bus.audio_in[DATA_W-1:0]})
                         + $signed({bus.audio_in[2*DATA_W-1], bus.audio_in[2*DATA_W-1:DATA_W]});
                for (int c = 0; c < CHANNELS; c++) begin
                    // Bits [DATA_W:1] are the DATA_W+1 sum shifted right arithmetically.
                    in_sample[c] = eff_mono ? mono_sum[DATA_W:1]
                                            : bus.audio_in[c*DATA_W +: DATA_W];
                end
            end
        end else begin : g_single
            logic unused_mono;
            assign unused_mono = eff_mono;
            always_comb begin
                in_sample[0] = bus.audio_in[DATA_W-1:0];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // MAC datapath
    // ------------------------------------------------------------------
    logic [TW-1:0]         rd_idx;
    logic [DATA_W-1:0]     x_rd;
    logic [COEF_W-1:0]     coef_k;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  acc_next;

    always_comb begin
        rd_idx   = wptr - k;               // wraps modulo TAPS because TAPS is a power of two
        x_rd     = dly[ch][rd_idx];
        coef_k   = coef_r[k*COEF_W +: COEF_W];
        prod     = $signed(x_rd) * $signed(coef_k);
        acc_next = acc + {{TW{prod[PW-1]}}, prod};
    end

    // ------------------------------------------------------------------
    // Scale / gain datapath
    // ------------------------------------------------------------------
    logic signed [AW-1:0]  acc_sh;
    logic [DATA_W-1:0]     f_val;
    logic [15:0]           lvl_ch;
    logic signed [GW-1:0]  gprod;
    logic signed [GW-1:0]  g_sh;
    logic [DATA_W-1:0]     y_val;

    always_comb begin
        acc_sh = acc >>> (COEF_W - 1);
        f_val  = filt_en ? sat_acc(acc_sh) : dly[ch][wptr];
        lvl_ch = level_r[ch*16 +: 16];
        gprod  = $signed(f_val) * $signed({1'b0, lvl_ch});
        g_sh   = gprod >>> 15;
        y_val  = sat_gain(g_sh);
    end

    // ------------------------------------------------------------------
    // Control FSM and all state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy_r    <= 1'b0;
            tick_r    <= 1'b0;
            audio_r   <= '0;
            wptr      <= '0;
            k         <= '0;
            ch        <= '0;
            acc       <= '0;
            filt_en   <= 1'b0;
            mono_en   <= 1'b0;
            coef_r    <= '0;
            level_r   <= {CHANNELS{16'h8000}};
            pend_cfg  <= 1'b0;
            pend_lvl  <= 1'b0;
            snap_filt <= 1'b0;
            snap_mono <= 1'b0;
            snap_coef <= '0;
            snap_lvl  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                shadow[c] <= '0;
                for (int t = 0; t < TAPS; t++) dly[c][t] <= '0;
            end
        end else begin
            tick_r <= 1'b0;
            if (bus.clr_in) begin
                // Clear has priority over everything, including a same-cycle tick.
                state    <= S_IDLE;
                busy_r   <= 1'b0;
                audio_r  <= '0;
                wptr     <= '0;
                k        <= '0;
                ch       <= '0;
                acc      <= '0;
                pend_cfg <= 1'b0;
                pend_lvl <= 1'b0;
                for (int c = 0; c < CHANNELS; c++) begin
                    shadow[c] <= '0;
                    for (int t = 0; t < TAPS; t++) dly[c][t] <= '0;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.cfg_in) begin
                            filt_en <= bus.cfg_reg_in[0];
                            mono_en <= bus.cfg_reg_in[1];
                            coef_r  <= bus.coef_in;
                        end
                        if (bus.level_in) level_r <= bus.level_reg_in;
                        if (bus.tick_in) begin
                            for (int c = 0; c < CHANNELS; c++) dly[c][wptr] <= in_sample[c];
                            ch     <= '0;
                            k      <= '0;
                            acc    <= '0;
                            busy_r <= 1'b1;
                            state  <= eff_filt ? S_MAC : S_SCALE;
                        end
                    end
                    S_MAC: begin
                        acc <= acc_next;
                        k   <= k + 1'b1;
                        if (k == TW'(TAPS - 1)) state <= S_SCALE;
                    end
                    S_SCALE: begin
                        shadow[ch] <= y_val;
                        acc        <= '0;
                        k          <= '0;
                        if (ch == CW'(CHANNELS - 1)) begin
                            state <= S_OUT;
                        end else begin
                            ch <= ch + 1'b1;
                            if (filt_en) state <= S_MAC;
                        end
                    end
                    S_OUT: begin
                        for (int c = 0; c < CHANNELS; c++) audio_r[c*DATA_W +: DATA_W] <= shadow[c];
                        tick_r <= 1'b1;
                        wptr   <= wptr + 1'b1;
                        busy_r <= 1'b0;
                        state  <= S_IDLE;
                        // Entering IDLE: a strobe in this very cycle beats an older pending one.
                        if (bus.cfg_in) begin
                            filt_en <= bus.cfg_reg_in[0];
                            mono_en <= bus.cfg_reg_in[1];
                            coef_r  <= bus.coef_in;
                        end else if (pend_cfg) begin
                            filt_en <= snap_filt;
                            mono_en <= snap_mono;
                            coef_r  <= snap_coef;
                        end
                        if (bus.level_in) level_r <= bus.level_reg_in;
                        else if (pend_lvl) level_r <= snap_lvl;
                        pend_cfg <= 1'b0;
                        pend_lvl <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase

                if (state == S_MAC || state == S_SCALE) begin
                    if (bus.cfg_in) begin
                        pend_cfg  <= 1'b1;
                        snap_filt <= bus.cfg_reg_in[0];
                        snap_mono <= bus.cfg_reg_in[1];
                        snap_coef <= bus.coef_in;
                    end
                    if (bus.level_in) begin
                        pend_lvl <= 1'b1;
                        snap_lvl <= bus.level_reg_in;
                    end
                end
            end
        end
    end

    assign bus.audio_out = audio_r;
    assign bus.tick_out  = tick_r;
    assign bus.busy_out  = busy_r;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_dsp_mc_unit.sv
module tb_dsp_mc_unit;
    localparam int CHANNELS = 2;
    localparam int TAPS     = 32;
    localparam int DATA_W   = 24;
    localparam int COEF_W   = 32;
    localparam int OW       = CHANNELS * DATA_W;
    localparam int LAT_F    = CHANNELS * (TAPS + 1) + 1;   // 67
    localparam int LAT_B    = CHANNELS + 1;                // 3

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dsp_mc_unit_if #(.CHANNELS(CHANNELS), .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W)) bus ();

    dsp_mc_unit #(.CHANNELS(CHANNELS), .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    logic [OW-1:0] exp_q[$];
    int            exp_t_q[$];

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every tick_out consumes one expected frame and its edge number.
    always @(negedge clk) begin
        if (rst_n && bus.tick_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected tick_out at edge %0d, audio_out %h, required no output", cyc, bus.audio_out);
            end else begin
                logic [OW-1:0] e;
                int t;
                e = exp_q.pop_front();
                t = exp_t_q.pop_front();
                check("audio_out", bus.audio_out, e);
                checks++;
                if (cyc != t) begin
                    errors++;
                    $display("FAIL latency: tick_out at edge %0d, expected edge %0d", cyc, t);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_frame(input logic [23:0] a0, input logic [23:0] a1,
                              input logic [23:0] e0, input logic [23:0] e1,
                              input int lat, input bit expect_out);
        bus.audio_in = {a1, a0};
        bus.tick_in  = 1'b1;
        if (expect_out) begin
            exp_q.push_back({e1, e0});
            exp_t_q.push_back(cyc + 1 + lat);
        end
        @(negedge clk);
        bus.tick_in = 1'b0;
    endtask

    task automatic pulse_cfg(input logic [31:0] cfg, input logic [31:0] c0, input logic [31:0] c1);
        logic [TAPS*COEF_W-1:0] coefs;
        coefs = '0;
        coefs[0 +: COEF_W]      = c0;
        coefs[COEF_W +: COEF_W] = c1;
        bus.cfg_reg_in = cfg;
        bus.coef_in    = coefs;
        bus.cfg_in     = 1'b1;
        @(negedge clk);
        bus.cfg_in = 1'b0;
    endtask

    task automatic pulse_level(input logic [15:0] l0, input logic [15:0] l1);
        bus.level_reg_in = {l1, l0};
        bus.level_in     = 1'b1;
        @(negedge clk);
        bus.level_in = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr_in = 1'b1;
        @(negedge clk);
        bus.clr_in = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain timeout: %0d outputs pending, required 0", exp_q.size());
            exp_q.delete();
            exp_t_q.delete();
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.tick_in      = 1'b0;
        bus.cfg_in       = 1'b0;
        bus.level_in     = 1'b0;
        bus.clr_in       = 1'b0;
        bus.audio_in     = '0;
        bus.coef_in      = '0;
        bus.level_reg_in = {16'h8000, 16'h8000};
        bus.cfg_reg_in   = '0;

        repeat (3) @(negedge clk);
        check("reset audio_out", bus.audio_out, '0);
        check("reset tick_out", OW'(bus.tick_out), '0);
        check("reset busy_out", OW'(bus.busy_out), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Bypass, unity gain (reset cfg/levels)
        send_frame(24'h123456, 24'hFEDCBA, 24'h123456, 24'hFEDCBA, LAT_B, 1'b1);
        wait_drain();

        // Bypass saturation with gain ~2.0
        pulse_level(16'hFFFF, 16'hFFFF);
        send_frame(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, LAT_B, 1'b1);
        wait_drain();
        send_frame(24'h800000, 24'h800000, 24'h800000, 24'h800000, LAT_B, 1'b1);
        wait_drain();
        pulse_level(16'h8000, 16'h8000);

        // Mono down-mix
        pulse_cfg(32'h2, 32'h0, 32'h0);
        send_frame(24'h000100, 24'h000301, 24'h000200, 24'h000200, LAT_B, 1'b1);
        wait_drain();

        // Impulse response, long enough for wptr to wrap
        pulse_cfg(32'h1, 32'h40000000, 32'h20000000);
        pulse_clr();
        send_frame(24'h200000, 24'h200000, 24'h100000, 24'h100000, LAT_F, 1'b1);
        wait_drain();
        send_frame(24'h0, 24'h0, 24'h080000, 24'h080000, LAT_F, 1'b1);
        wait_drain();
        for (int i = 0; i < 34; i++) begin
            send_frame(24'h0, 24'h0, 24'h0, 24'h0, LAT_F, 1'b1);
            wait_drain();
        end

        // tick_in at E+5 is dropped: no second output, no sample write
        pulse_clr();
        send_frame(24'h200000, 24'h200000, 24'h100000, 24'h100000, LAT_F, 1'b1);
        repeat (4) @(negedge clk);
        check("busy_out mid-frame", OW'(bus.busy_out), OW'(1));
        bus.audio_in = {24'h7FFFFF, 24'h7FFFFF};
        bus.tick_in  = 1'b1;
        @(negedge clk);
        bus.tick_in = 1'b0;
        wait_drain();
        send_frame(24'h0, 24'h0, 24'h080000, 24'h080000, LAT_F, 1'b1);
        wait_drain();

        // level_in at E+10: applied only from the next frame
        pulse_clr();
        send_frame(24'h200000, 24'h200000, 24'h100000, 24'h100000, LAT_F, 1'b1);
        repeat (9) @(negedge clk);
        pulse_level(16'h4000, 16'h4000);
        wait_drain();
        send_frame(24'h0, 24'h0, 24'h040000, 24'h040000, LAT_F, 1'b1);
        wait_drain();
        pulse_level(16'h8000, 16'h8000);

        // clr_in at E+10: frame aborted, outputs zeroed, next impulse clean
        pulse_clr();
        send_frame(24'h200000, 24'h200000, 24'h0, 24'h0, LAT_F, 1'b0);
        repeat (9) @(negedge clk);
        pulse_clr();
        repeat (80) @(negedge clk);
        check("audio_out after clr", bus.audio_out, '0);
        check("busy_out after clr", OW'(bus.busy_out), '0);
        send_frame(24'h200000, 24'h200000, 24'h100000, 24'h100000, LAT_F, 1'b1);
        wait_drain();
        send_frame(24'h0, 24'h0, 24'h080000, 24'h080000, LAT_F, 1'b1);
        wait_drain();
        send_frame(24'h0, 24'h0, 24'h0, 24'h0, LAT_F, 1'b1);
        wait_drain();

        // Filter saturation: near-unity taps on a full-scale step
        pulse_cfg(32'h1, 32'h7FFFFFFF, 32'h7FFFFFFF);
        pulse_clr();
        send_frame(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFE, 24'h7FFFFE, LAT_F, 1'b1);
        wait_drain();
        send_frame(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, LAT_F, 1'b1);
        wait_drain();

        // Asynchronous reset in the middle of MAC
        pulse_level(16'h4000, 16'h4000);
        send_frame(24'h7FFFFF, 24'h7FFFFF, 24'h0, 24'h0, LAT_F, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid-frame reset audio_out", bus.audio_out, '0);
        check("mid-frame reset tick_out", OW'(bus.tick_out), '0);
        check("mid-frame reset busy_out", OW'(bus.busy_out), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // cfg back to bypass and level back to 0x8000 after reset
        send_frame(24'h123456, 24'hFEDCBA, 24'h123456, 24'hFEDCBA, LAT_B, 1'b1);
        wait_drain();

        repeat (5) @(negedge clk);
        check("scoreboard empty", OW'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at edge %0d, required completion", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dsp_mc_unit.md
# dsp_mc_unit

Parametrised multi-channel successor to the audioport DSP datapath. It sits between the register/control front end and the serialiser. Per-channel input samples are captured on each `tick_in` and passed through an optional TAPS-tap FIR filter, computed with a single time-shared MAC. A per-channel level gain, optional mono down-mix and output saturation follow. All channel outputs are presented together with a one-cycle `tick_out`.

## Interface
- `CHANNELS`, default 2: number of audio channels (≥1).
- `TAPS`, default 32: FIR length per channel (≥2, power of two).
- `DATA_W`, default 24: signed sample width.
- `COEF_W`, default 32: signed coefficient width, Q1.(COEF_W-1).
- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick_in` in 1: one-cycle pulse that starts processing of one sample frame.
- `cfg_in` in 1: one-cycle pulse that loads `cfg_reg_in` and `coef_in`.
- `level_in` in 1: one-cycle pulse that loads `level_reg_in`.
- `clr_in` in 1: one-cycle pulse that clears filter state and outputs.
- `audio_in` in CHANNELS*DATA_W: input samples; channel c is at bits [c*DATA_W +: DATA_W].
- `coef_in` in TAPS*COEF_W: coefficient k is at bits [k*COEF_W +: COEF_W], shared by all channels.
- `level_reg_in` in CHANNELS*16: per-channel unsigned Q1.15 gain; 0x8000 = 1.0.
- `cfg_reg_in` in 32: bit0 = filter enable; bit1 = mono; other bits ignored.
- `audio_out` out CHANNELS*DATA_W: processed samples, same packing as `audio_in`.
- `tick_out` out 1: one-cycle pulse, asserted in the same cycle that `audio_out` updates.
- `busy_out` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Reset values:**
  - `audio_out`, `tick_out`, `busy_out`: 0.
  - cfg register and all coefficients: 0.
  - Level registers: 0x8000.
  - Delay lines and write pointer: 0.
  - FSM: IDLE.
- **States:** IDLE, MAC, SCALE, OUT.
- **IDLE + `tick_in`:**
  - Write `audio_in` into each channel's circular delay line at `wptr`.
  - If mono is set and CHANNELS≥2, every channel instead receives (ch0+ch1)>>>1, using an arithmetic shift on a DATA_W+1 sum. Mono is ignored when CHANNELS=1.
  - Set ch=0 and k=0.
  - Go to MAC if filter enable is set, otherwise go to SCALE.
- **MAC:**
  - One product per cycle: acc += x[ch][(wptr−k) mod TAPS] * coef[k].
  - acc is signed, DATA_W+COEF_W+log2(TAPS) bits, and is cleared when a channel starts.
  - After k=TAPS−1, go to SCALE.
- **SCALE (one cycle per channel):**
  - Compute f = sat(acc>>>(COEF_W−1)) when filtering, or f = the newest sample when bypassed.
  - Compute y = sat((f*level[ch])>>>15).
  - Write y to result shadow register ch.
  - If ch<CHANNELS−1, increment ch and go to MAC (or stay in SCALE when bypassed). Otherwise go to OUT.
- **OUT:**
  - Copy all shadow registers to `audio_out` and assert `tick_out` in this single cycle.
  - Increment `wptr` modulo TAPS, wrapping naturally.
  - Go to IDLE.
- **Saturation:** clamp to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. Intermediate products are full precision.
- **`tick_in` while busy:** dropped. The sample is not written and `wptr` is unchanged.
- **`cfg_in` / `level_in`:**
  - In IDLE they load immediately.
  - While busy they are latched as pending, together with a snapshot of the input values, and applied on entry to IDLE.
  - If they coincide with `tick_in` in IDLE, the load happens first and the frame uses the new values.
- **`clr_in`:**
  - In any state it zeroes delay lines, `wptr`, shadow registers, `audio_out` and pending flags, and forces IDLE with no `tick_out`.
  - cfg, coefficient and level registers are kept.
  - If it coincides with `tick_in`, the clear wins and the tick is dropped.

## Timing
- `tick_in` is sampled at edge E.
- **Filter enabled:** `audio_out` and `tick_out` change at edge E + CHANNELS*(TAPS+1) + 1. With default parameters that is E+67.
- **Bypassed:** the change happens at edge E + CHANNELS + 1 (E+3 by default).
- `tick_out` is high for exactly one cycle. `audio_out` holds its value until the next OUT or clear.
- `busy_out` is high from E+1 until the OUT cycle inclusive.
- Minimum `tick_in` spacing without drops is the latency + 1.
- An asynchronous `rst_n` assertion mid-frame returns all state to reset values immediately.

## Test plan
- **Reset:** assert `rst_n`=0 mid-MAC → `audio_out`=0, `tick_out`=0, `busy_out`=0; after release, levels are 0x8000.
- **Bypass, unity gain:** cfg=0, ch0=0x123456, ch1=0xFEDCBA, `tick_in` → `tick_out` at E+3 with those exact values.
- **Impulse response:**
  - Setup: cfg=1, coef0=0x40000000, coef1=0x20000000, others 0.
  - Stimulus: 0x200000, then zeros, on both channels.
  - Required: outputs 0x100000, then 0x080000, then 0; `tick_out` at E+67 each frame; after 32+ frames `wptr` has wrapped and output stays 0.
- **Saturation:**
  - Gain 0xFFFF, bypass: 0x7FFFFF → 0x7FFFFF, and 0x800000 → 0x800000.
  - Filter with coef0=coef1=0x7FFFFFFF and a 0x7FFFFF step: second frame → 0x7FFFFF.
- **Mono:** cfg=2, ch0=0x000100, ch1=0x000301 → both outputs 0x000200.
- **Control collisions:**
  - `tick_in` at E+5 during a frame → dropped, single `tick_out`.
  - `level_in` (gain 0x4000) at E+10 → current frame keeps the old gain, next frame is halved.
  - `clr_in` at E+10 → no `tick_out`, `audio_out`=0, and the next impulse gives a clean response.
